// File: rtl/rf_wb_scheduler_if.sv
// Writeback-scheduler bus: two writeback sources, register-file write port,
// issue handshake and hazard-check lookups.
interface rf_wb_scheduler_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  req0_valid;
  logic [4:0]            req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [4:0]            req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  iss_valid;
  logic [4:0]            iss_addr;
  logic                  iss_ready;
  logic [4:0]            chk_addr1;
  logic [4:0]            chk_addr2;
  logic                  busy1;
  logic                  busy2;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output iss_valid, iss_addr, chk_addr1, chk_addr2,
    input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, iss_ready, busy1, busy2
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  iss_valid, iss_addr, chk_addr1, chk_addr2,
    output req0_ready, req1_ready, wr_en, wr_addr, wr_data, iss_ready, busy1, busy2
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback arbiter (2 sources, 1-bit round robin) with a
// pending-write scoreboard used for WAW issue stalls and RAW hazard lookups.
module rf_wb_scheduler #(
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  rf_wb_scheduler_if.slave bus
);

  logic                  grant0_s;
  logic                  grant1_s;
  logic                  xfer_s;
  logic [4:0]            xfer_addr_s;
  logic [DATA_WIDTH-1:0] xfer_data_s;
  logic                  iss_ready_s;
  logic                  iss_fire_s;

  logic                  wr_en_d,   wr_en_q;
  logic [4:0]            wr_addr_d, wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;
  logic                  last_d,    last_q;
  logic [31:0]           pending_d, pending_q;

  // Arbitration: last_q is the most recently granted source; the other one wins a contest.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      if (last_q) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (bus.req0_valid) begin
      grant0_s = 1'b1;
    end else if (bus.req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Granted payload mux and issue acceptance.
  always_comb begin
    xfer_s = grant0_s | grant1_s;
    if (grant1_s) begin
      xfer_addr_s = bus.req1_addr;
      xfer_data_s = bus.req1_data;
    end else begin
      xfer_addr_s = bus.req0_addr;
      xfer_data_s = bus.req0_data;
    end
    iss_ready_s = !reset && ((bus.iss_addr == 5'd0) || !pending_q[bus.iss_addr]);
    iss_fire_s  = bus.iss_valid && iss_ready_s && (bus.iss_addr != 5'd0);
  end

  // Next-state: write port capture, pointer update, scoreboard clear then set (set wins).
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    pending_d = pending_q;
    if (xfer_s) begin
      wr_en_d   = (xfer_addr_s != 5'd0);
      wr_addr_d = xfer_addr_s;
      wr_data_d = xfer_data_s;
      last_d    = grant1_s;
      pending_d[xfer_addr_s] = 1'b0;
    end else begin
      wr_en_d = 1'b0;
    end
    if (iss_fire_s) begin
      pending_d[bus.iss_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset leaves source 0 as the first contended winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= {DATA_WIDTH{1'b0}};
      last_q    <= 1'b1;
      pending_q <= 32'd0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;
  assign bus.iss_ready  = iss_ready_s;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  // Hazard lookups see registered scoreboard only.
  assign bus.busy1      = (bus.chk_addr1 != 5'd0) && pending_q[bus.chk_addr1];
  assign bus.busy2      = (bus.chk_addr2 != 5'd0) && pending_q[bus.chk_addr2];

endmodule
